// File: rtl/spi_slave_gen.sv
// spi_slave_gen: system-clock-synchronous SPI slave bridging a serial master to the
// single-port RAM command interface.
//
// A frame is 2 + DATA_W bits: a 2-bit command (cmd[1] first) followed by the payload.
// Every rising clk edge with SS_n low moves one bit. Completed frames appear on rx_data
// with a one-cycle rx_valid strobe. A read-data command (11) that follows a read-address
// command (10) waits for tx_valid, then shifts the returned word out on MISO.
// Protocol problems raise a one-cycle frame_err: SS_n released mid-frame, read data
// without a prior read address, or a response timeout.
//
// Parameters:
//   DATA_W     payload / RAM word width (>= 2)
//   LSB_FIRST  0: payload MSB-first on MOSI and MISO; 1: LSB-first on both
//   TX_TIMEOUT cycles allowed in WAIT_TX before the response is declared lost (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   SS_n       slave select, active-low
//   MOSI       serial data in
//   tx_valid   RAM read data valid (only honoured while waiting for a response)
//   tx_data    RAM read data
//   MISO       serial data out, registered
//   rx_valid   one-cycle strobe, rx_data holds a complete frame
//   rx_data    {cmd[1:0], payload}, MSB is always the first command bit
//   frame_err  one-cycle strobe on abort, sequence or timeout error

module spi_slave_gen #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LSB_FIRST  = 0,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              frame_err
);

  localparam int unsigned N    = DATA_W + 2;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned ToW  = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StRx,
    StWaitTx,
    StTx,
    StDone
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [ToW-1:0]    to_cnt_q;
  logic [N-1:0]      shift_q;
  logic              rd_addr_seen_q;

  logic [IdxW-1:0]   rx_pos;
  logic [N-1:0]      rx_shift_next;
  logic [1:0]        rx_cmd;
  logic              tx_bit;
  logic [ToW-1:0]    to_cnt_inc;

  // The receive register is cleared at frame start, so each bit is written straight to
  // its final position. Command bits always fill the top two positions in arrival order;
  // in LSB-first mode payload bit i arrives as frame bit i + 2 and lands at index i.
  always_comb begin
    rx_pos = IdxW'(CntW'(N - 1) - bit_cnt_q);
    if (LSB_FIRST != 0 && bit_cnt_q >= CntW'(2)) begin
      rx_pos = IdxW'(bit_cnt_q - CntW'(2));
    end
    rx_shift_next         = shift_q;
    rx_shift_next[rx_pos] = MOSI;
    rx_cmd                = rx_shift_next[N-1:N-2];
  end

  // Transmit word sits in the low DATA_W bits of the shared shift register.
  always_comb begin
    tx_bit     = (LSB_FIRST != 0) ? shift_q[0] : shift_q[DATA_W-1];
    to_cnt_inc = to_cnt_q + ToW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      to_cnt_q       <= '0;
      shift_q        <= '0;
      rd_addr_seen_q <= 1'b0;
      MISO           <= 1'b0;
      rx_valid       <= 1'b0;
      rx_data        <= '0;
      frame_err      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // The edge that sees SS_n fall only opens the frame; no bit is taken here.
          if (!SS_n) begin
            state_q   <= StRx;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
          end
        end

        StRx: begin
          if (SS_n) begin
            state_q   <= StIdle;
            MISO      <= 1'b0;
            frame_err <= 1'b1;
          end else begin
            shift_q <= rx_shift_next;
            if (bit_cnt_q == CntW'(N - 1)) begin
              rx_data <= rx_shift_next;
              unique case (rx_cmd)
                2'b00, 2'b01: begin
                  rx_valid <= 1'b1;
                  state_q  <= StDone;
                end
                2'b10: begin
                  rx_valid       <= 1'b1;
                  rd_addr_seen_q <= 1'b1;
                  state_q        <= StDone;
                end
                2'b11: begin
                  if (rd_addr_seen_q) begin
                    rx_valid       <= 1'b1;
                    rd_addr_seen_q <= 1'b0;
                    to_cnt_q       <= '0;
                    state_q        <= StWaitTx;
                  end else begin
                    frame_err <= 1'b1;
                    state_q   <= StDone;
                  end
                end
                default: state_q <= StDone;
              endcase
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
        end

        StWaitTx: begin
          // A response arriving on the expiry edge still wins over the timeout.
          if (SS_n) begin
            state_q   <= StIdle;
            MISO      <= 1'b0;
            frame_err <= 1'b1;
          end else if (tx_valid) begin
            shift_q   <= {2'b00, tx_data};
            bit_cnt_q <= '0;
            state_q   <= StTx;
          end else begin
            to_cnt_q <= to_cnt_inc;
            if (to_cnt_inc == ToW'(TX_TIMEOUT)) begin
              frame_err <= 1'b1;
              state_q   <= StDone;
            end
          end
        end

        StTx: begin
          if (SS_n) begin
            state_q   <= StIdle;
            MISO      <= 1'b0;
            frame_err <= 1'b1;
          end else if (bit_cnt_q == CntW'(DATA_W)) begin
            MISO    <= 1'b0;
            state_q <= StDone;
          end else begin
            MISO      <= tx_bit;
            bit_cnt_q <= bit_cnt_q + CntW'(1);
            if (LSB_FIRST != 0) begin
              shift_q <= {1'b0, shift_q[N-1:1]};
            end else begin
              shift_q <= {shift_q[N-2:0], 1'b0};
            end
          end
        end

        StDone: begin
          if (SS_n) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Scoreboard bench for spi_slave_gen. Two instances are exercised one after the other:
// A (DATA_W=8, MSB-first, TX_TIMEOUT=4) and B (DATA_W=16, LSB-first, TX_TIMEOUT=6).
// The driver walks a transaction-level model (frame contents, read-address flag, edge
// numbers) and queues the expected strobes and MISO words; a negedge monitor checks them.

module tb_spi_slave_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = 16'h0;
  int          cur = 0;

  logic        ss_n_a, ss_n_b;
  logic        miso_a, rx_valid_a, frame_err_a;
  logic [9:0]  rx_data_a;
  logic        miso_b, rx_valid_b, frame_err_b;
  logic [17:0] rx_data_b;

  assign ss_n_a = (cur == 0) ? ss_n : 1'b1;
  assign ss_n_b = (cur == 1) ? ss_n : 1'b1;

  spi_slave_gen #(.DATA_W(8), .LSB_FIRST(0), .TX_TIMEOUT(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (ss_n_a),
    .MOSI      (mosi),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data[7:0]),
    .MISO      (miso_a),
    .rx_valid  (rx_valid_a),
    .rx_data   (rx_data_a),
    .frame_err (frame_err_a)
  );

  spi_slave_gen #(.DATA_W(16), .LSB_FIRST(1), .TX_TIMEOUT(6)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (ss_n_b),
    .MOSI      (mosi),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .MISO      (miso_b),
    .rx_valid  (rx_valid_b),
    .rx_data   (rx_data_b),
    .frame_err (frame_err_b)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          inst;
    int          kind;   // 0: rx_valid, 1: frame_err
    int          t;
    logic [17:0] data;
  } ev_t;

  typedef struct {
    int          inst;
    int          start;
    logic [15:0] word;
    int          width;
    int          lsb;
  } tx_t;

  ev_t evq[$];
  tx_t txq[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;

  int dw  = 8;
  int lsb = 0;
  int tmo = 4;
  int seen[2];

  function automatic logic frame_bit(input logic [17:0] fr, input int i);
    int n;
    n = dw + 2;
    if (lsb == 0 || i < 2) return fr[n-1-i];
    return fr[i-2];
  endfunction

  function automatic logic [17:0] cur_rx_data();
    return (cur == 0) ? {8'h00, rx_data_a} : rx_data_b;
  endfunction

  task automatic push_ev(input int kind, input int t, input logic [17:0] data);
    ev_t e;
    e.inst = cur;
    e.kind = kind;
    e.t    = t;
    e.data = data;
    evq.push_back(e);
  endtask

  task automatic push_tx(input int start, input logic [15:0] word);
    tx_t x;
    x.inst  = cur;
    x.start = start;
    x.word  = word;
    x.width = dw;
    x.lsb   = lsb;
    txq.push_back(x);
  endtask

  task automatic mon_inst(input int d, input logic rv, input logic fe, input logic mo,
                          input logic [17:0] rd);
    ev_t         e;
    logic        exp_mo;
    int          idx;
    logic [15:0] wv;
    if (rv === 1'b1 && fe === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL strobe_excl inst%0d edge %0d: rx_valid=1 frame_err=1, required not both",
               d, edge_n);
    end
    if (rv === 1'b1) begin
      n_tests++;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected inst%0d edge %0d: rx_valid=1 data=%h, required no event",
                 d, edge_n, rd);
      end else begin
        e = evq.pop_front();
        if (e.inst != d || e.kind != 0 || e.t != edge_n || e.data !== rd) begin
          n_fail++;
          $display("FAIL rx_event inst%0d: got rx_valid edge %0d data=%h, required inst%0d kind=%0d edge %0d data=%h",
                   d, edge_n, rd, e.inst, e.kind, e.t, e.data);
        end
      end
    end
    if (fe === 1'b1) begin
      n_tests++;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL err_unexpected inst%0d edge %0d: frame_err=1, required no event",
                 d, edge_n);
      end else begin
        e = evq.pop_front();
        if (e.inst != d || e.kind != 1 || e.t != edge_n) begin
          n_fail++;
          $display("FAIL err_event inst%0d: got frame_err edge %0d, required inst%0d kind=%0d edge %0d",
                   d, edge_n, e.inst, e.kind, e.t);
        end
      end
    end
    exp_mo = 1'b0;
    if (txq.size() > 0 && txq[0].inst == d && edge_n >= txq[0].start) begin
      idx = edge_n - txq[0].start;
      wv  = txq[0].word;
      if (idx < txq[0].width) begin
        exp_mo = (txq[0].lsb != 0) ? wv[4'(idx)] : wv[4'(txq[0].width - 1 - idx)];
      end else begin
        void'(txq.pop_front());
      end
    end
    n_tests++;
    if (mo !== exp_mo) begin
      n_fail++;
      $display("FAIL miso inst%0d edge %0d: got %b, required %b", d, edge_n, mo, exp_mo);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_inst(0, rx_valid_a, frame_err_a, miso_a, {8'h00, rx_data_a});
      mon_inst(1, rx_valid_b, frame_err_b, miso_b, rx_data_b);
      if (evq.size() > 0 && evq[0].t < edge_n) begin
        n_tests++;
        n_fail++;
        $display("FAIL event_missing inst%0d: absent at edge %0d, required kind=%0d at edge %0d",
                 evq[0].inst, edge_n, evq[0].kind, evq[0].t);
        void'(evq.pop_front());
      end
    end
  end

  task automatic check_zero(input int d, input string tag);
    logic        mo, rv, fe;
    logic [17:0] rd;
    mo = (d == 0) ? miso_a : miso_b;
    rv = (d == 0) ? rx_valid_a : rx_valid_b;
    fe = (d == 0) ? frame_err_a : frame_err_b;
    rd = (d == 0) ? {8'h00, rx_data_a} : rx_data_b;
    n_tests += 4;
    if (mo !== 1'b0) begin
      n_fail++; $display("FAIL %s_miso inst%0d: got %b, required 0", tag, d, mo);
    end
    if (rv !== 1'b0) begin
      n_fail++; $display("FAIL %s_rx_valid inst%0d: got %b, required 0", tag, d, rv);
    end
    if (fe !== 1'b0) begin
      n_fail++; $display("FAIL %s_frame_err inst%0d: got %b, required 0", tag, d, fe);
    end
    if (rd !== 18'h0) begin
      n_fail++; $display("FAIL %s_rx_data inst%0d: got %h, required 0", tag, d, rd);
    end
  endtask

  // c: command, p: payload, abort_bits: bits sent before SS_n rises (-1 none),
  // j: WAIT_TX edge on which tx_valid is sampled (> tmo: never), abort_wait: WAIT_TX edge
  // on which SS_n rises (0 none), w: response word, rst_at: TX step at which reset hits.
  task automatic do_frame(input int c, input logic [15:0] p, input int abort_bits, input int j,
                          input int abort_wait, input logic [15:0] w, input int rst_at);
    int          n;
    logic [17:0] fr;
    logic [15:0] pm, wm;
    bit          early;
    int          k;
    n  = dw + 2;
    pm = (dw == 16) ? p : (p & 16'h00ff);
    wm = (dw == 16) ? w : (w & 16'h00ff);
    fr = (18'(c[1:0]) << dw) | 18'(pm);
    early = 1'b0;

    ss_n = 1'b0;
    mosi = 1'($urandom);
    @(posedge clk); #1;
    n_tests++;
    if (cur_rx_data() !== 18'h0) begin
      n_fail++;
      $display("FAIL rx_clear inst%0d edge %0d: got %h, required 0", cur, edge_n, cur_rx_data());
    end

    for (int i = 0; i < n; i++) begin
      if (i == abort_bits) begin
        ss_n = 1'b1;
        @(posedge clk); #1;
        push_ev(1, edge_n, 18'h0);
        early = 1'b1;
        break;
      end
      mosi     = frame_bit(fr, i);
      tx_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;

    if (!early) begin
      if (c != 3) begin
        push_ev(0, edge_n, fr);
        if (c == 2) seen[cur] = 1;
      end else if (seen[cur] == 0) begin
        push_ev(1, edge_n, fr);
      end else begin
        push_ev(0, edge_n, fr);
        seen[cur] = 0;
        for (int m = 1; m <= tmo; m++) begin
          if (abort_wait == m && abort_wait < j) begin
            ss_n = 1'b1;
            @(posedge clk); #1;
            push_ev(1, edge_n, 18'h0);
            break;
          end
          if (m == j) begin
            tx_valid = 1'b1;
            tx_data  = wm;
            @(posedge clk); #1;
            k = edge_n;
            push_tx(k + 1, wm);
            tx_data = 16'($urandom);
            for (int i = 0; i <= dw; i++) begin
              if (i == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                txq.delete();
                check_zero(cur, "reset_mid_tx");
                rst_n   = 1'b1;
                ss_n    = 1'b1;
                seen[0] = 0;
                seen[1] = 0;
                break;
              end
              tx_valid = 1'($urandom);
              mosi     = 1'($urandom);
              @(posedge clk); #1;
            end
            tx_valid = 1'b0;
            break;
          end
          @(posedge clk); #1;
          if (m == tmo) push_ev(1, edge_n, 18'h0);
        end
      end
    end

    ss_n = 1'b1;
    repeat ($urandom_range(3, 1)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic random_frames(input int count);
    int c, ab, j, aw;
    for (int f = 0; f < count; f++) begin
      if ($urandom_range(2, 0) == 0) begin
        do_frame(2, 16'($urandom), -1, 0, 0, 16'h0, -1);
        c = 3;
      end else begin
        c = int'($urandom_range(3, 0));
      end
      ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(dw + 1, 0)) : -1;
      j  = int'($urandom_range(tmo + 1, 1));
      aw = ($urandom_range(7, 0) == 0) ? int'($urandom_range(tmo, 1)) : 0;
      do_frame(c, 16'($urandom), ab, j, aw, 16'($urandom), -1);
    end
  endtask

  initial begin
    seen[0] = 0;
    seen[1] = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Instance A: DATA_W=8, MSB-first, TX_TIMEOUT=4
    cur = 0; dw = 8; lsb = 0; tmo = 4;
    do_frame(0, 16'h00A5, -1, 0, 0, 16'h0, -1);     // write address, rx_data 0A5
    do_frame(2, 16'h0003, -1, 0, 0, 16'h0, -1);     // read address
    do_frame(3, 16'h005A, -1, 3, 0, 16'h00C3, -1);  // read data, MISO 11000011
    do_frame(3, 16'h0011, -1, 1, 0, 16'h0, -1);     // read data without address
    do_frame(2, 16'h0042, -1, 0, 0, 16'h0, -1);
    do_frame(3, 16'h0000, -1, 5, 0, 16'h0, -1);     // timeout after 4 cycles
    do_frame(3, 16'h0000, -1, 4, 0, 16'h00E7, -1);  // no address: error
    do_frame(2, 16'h0001, -1, 0, 0, 16'h0, -1);
    do_frame(3, 16'h0000, -1, 4, 0, 16'h00E7, -1);  // tx_valid on the expiry edge wins
    do_frame(1, 16'h00F0, 5, 0, 0, 16'h0, -1);      // abort after 5 bits
    do_frame(1, 16'h00F0, -1, 0, 0, 16'h0, -1);     // rx_data 1F0
    random_frames(120);

    // Instance B: DATA_W=16, LSB-first, TX_TIMEOUT=6
    cur = 1; dw = 16; lsb = 1; tmo = 6;
    do_frame(2, 16'h1234, -1, 0, 0, 16'h0, -1);
    do_frame(3, 16'hBEEF, -1, 2, 0, 16'h8001, -1);  // 8001 shifted LSB first
    do_frame(0, 16'h8001, -1, 0, 0, 16'h0, -1);
    random_frames(120);
    do_frame(2, 16'h0F0F, -1, 0, 0, 16'h0, -1);
    do_frame(3, 16'h0000, -1, 1, 0, 16'hA5C3, 5);   // reset mid-TX
    do_frame(3, 16'h0000, -1, 1, 0, 16'h0, -1);     // reset cleared the read address
    do_frame(1, 16'h5555, -1, 0, 0, 16'h0, -1);

    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (evq.size() != 0) begin
      n_fail++;
      $display("FAIL events_pending: got %0d left, required 0", evq.size());
    end
    n_tests++;
    if (txq.size() != 0) begin
      n_fail++;
      $display("FAIL tx_pending: got %0d left, required 0", txq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_gen.md
# spi_slave_gen

Parametrised, system-clock-synchronous SPI slave that bridges a serial master to the single-port RAM command interface. Receives `2 + DATA_W`-bit frames (2-bit command + payload), presents them on `rx_data` with a one-cycle `rx_valid` strobe, and, for read-data commands, waits for `tx_valid` and shifts the returned word out on `MISO`. Compared with the fixed 10-bit slave, it adds:
- configurable word width and bit order;
- read-address sequencing checks;
- a response timeout;
- abort and error reporting.

## Interface
Parameters:
- `DATA_W`, 8, payload/RAM word width (≥ 2); frame length `N = DATA_W + 2`
- `LSB_FIRST`, 0, 0: MSB-first on both MOSI and MISO; 1: LSB-first on both
- `TX_TIMEOUT`, 16, max cycles in WAIT_TX before error (≥ 1)

Ports (reset `rst_n`: synchronous, active-low; clock `clk`):
- `clk`  in  1  system clock; all sampling on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `SS_n`  in  1  slave select, active-low
- `MOSI`  in  1  serial data in, one bit per `clk` while `SS_n` = 0
- `tx_valid`  in  1  RAM read data valid
- `tx_data`  in  `DATA_W`  RAM read data
- `MISO`  out  1  serial data out (registered)
- `rx_valid`  out  1  one-cycle strobe: `rx_data` holds a complete frame
- `rx_data`  out  `DATA_W+2`  `{cmd[1:0], payload}`, always MSB = first command bit
- `frame_err`  out  1  one-cycle strobe on abort/sequence/timeout error

## Operation
- States: IDLE, RX, WAIT_TX, TX, DONE.
- **Reset:** state IDLE; all of the following are 0: `MISO`, `rx_valid`, `rx_data`, `frame_err`, bit counter, timeout counter, shift register, `rd_addr_seen`.
- **IDLE:** if `SS_n` = 0, go to RX with bit counter = 0. No bit is captured on that edge.
- **RX:** each edge with `SS_n` = 0 captures `MOSI`.
  - MSB-first: shift left into `rx_data` (LSB end).
  - LSB-first: the payload is assembled so that `rx_data` is bit-identical to the MSB-first case for the same logical word. The command bits are always sent first, `cmd[1]` before `cmd[0]`.
- **Edge capturing bit N:** `rx_data` is updated, then the command is decoded:
  - cmd 00 (write addr), 01 (write data): `rx_valid` = 1; go to DONE.
  - cmd 10 (read addr): `rx_valid` = 1; set `rd_addr_seen`; go to DONE.
  - cmd 11 (read data) with `rd_addr_seen` = 1: `rx_valid` = 1; clear `rd_addr_seen`; clear timeout counter; go to WAIT_TX.
  - cmd 11 with `rd_addr_seen` = 0: `rx_valid` stays 0; `frame_err` = 1; go to DONE.
- **WAIT_TX:**
  - `tx_valid` = 1: load `tx_data` into the shift register; go to TX with bit counter = 0.
  - Otherwise increment the timeout counter. On the edge where the count reaches `TX_TIMEOUT`: `frame_err` = 1; go to DONE.
  - `tx_valid` outside WAIT_TX is ignored.
- **TX:** each edge drives `MISO` with the next bit (MSB or LSB per `LSB_FIRST`).
  - After `DATA_W` bits, go to DONE.
  - On the DONE-entry edge `MISO` = 0.
- **DONE:** ignore `MOSI`; go to IDLE when `SS_n` = 1.
- **Abort:** `SS_n` = 1 sampled in RX, WAIT_TX or TX:
  - go to IDLE next edge and discard the partial frame;
  - no `rx_valid`; `MISO` = 0; `frame_err` = 1 for one cycle;
  - `rd_addr_seen` keeps its value, except a cmd 11 already accepted has cleared it.
- **Other rules:**
  - `SS_n` = 1 in IDLE/DONE: no error.
  - `rx_data` holds its value until the next frame completes. A new frame (IDLE→RX) clears it to 0.
  - `rst_n` = 0 has priority over all events, including mid-frame. State returns to IDLE at once.

## Timing
- Edge 0: IDLE samples `SS_n` = 0. Bits are captured on edges 1..N. `rx_valid`/`rx_data` are valid in the cycle after edge N (latency N+1 cycles from `SS_n` low).
- `rx_valid` and `frame_err` are exactly one cycle wide and never asserted in the same cycle.
- `tx_valid` sampled on edge k in WAIT_TX: the first `MISO` bit is valid after edge k+1; the last after edge k+DATA_W; `MISO` = 0 after edge k+DATA_W+1.
- `tx_valid` on the same edge the timeout expires: `tx_valid` wins, no error.
- Minimum `SS_n` high time between frames: 1 cycle (DONE→IDLE→RX).

## Test plan
- **Write address**, `DATA_W` = 8, MSB-first: `SS_n` low, MOSI = 00_1010_0101 → `rx_valid` one cycle after the 10th bit; `rx_data` = 10'h0A5; `frame_err` = 0.
- **Read sequence:** frame 10_0000_0011, then frame 11_xxxx_xxxx, then `tx_valid` with `tx_data` = 8'hC3 two cycles later → two `rx_valid` pulses; `MISO` = 1,1,0,0,0,0,1,1 on consecutive cycles; then 0.
- **Read data without prior read address** → `frame_err` pulse after bit 10; no `rx_valid`; `MISO` stays 0.
- **Timeout:** `TX_TIMEOUT` = 4, accepted cmd 11, `tx_valid` never asserted → `frame_err` pulse exactly 4 cycles after entering WAIT_TX; then IDLE after `SS_n` high.
- **Abort:** `SS_n` high after 5 bits → `frame_err` one cycle; no `rx_valid`. A following full cmd 01 frame (01_1111_0000) yields `rx_data` = 10'h1F0.
- **Parameter/reset:** `DATA_W` = 16, `LSB_FIRST` = 1 → a read returns 16'h8001 shifted out LSB first. Assert `rst_n` = 0 mid-TX → all outputs 0 on the next edge.
